// File: rtl/imem_fetch_unit.sv
// Pipelined instruction memory for the fetch stage: valid/ready requests, credit-limited
// output FIFO, flush on mispredict, and a program-load write port.
module imem_fetch_unit #(
    parameter int    IDX_W     = 10,
    parameter int    LATENCY   = 1,
    parameter int    OUT_DEPTH = 2,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_pc,
    output logic [31:0] resp_instr,
    output logic        resp_fault,
    input  logic        flush,
    input  logic        ld_we,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int CW    = $clog2(OUT_DEPTH + 1);
    localparam int PW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    logic [CW-1:0]    r_credits;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [31:0]      r_mem [DEPTH];
    logic [31:0]      r_rd_data;
    logic [31:0]      r_f_pc    [OUT_DEPTH];
    logic [31:0]      r_f_instr [OUT_DEPTH];
    logic             r_f_fault [OUT_DEPTH];

    logic             w_accept;
    logic             w_fault;
    logic             w_push;
    logic             w_pop;
    logic [IDX_W-1:0] w_req_idx;
    logic [IDX_W-1:0] w_ld_idx;
    logic             w_ld_unused;
    logic             w_v   [LATENCY];
    logic             w_flt [LATENCY];
    logic [31:0]      w_pc  [LATENCY];
    logic [31:0]      w_dat [LATENCY];

    assign req_ready   = (r_credits != '0);
    assign w_accept    = req_valid & req_ready;
    assign w_fault     = (req_pc[1:0] != 2'b00) | (req_pc[31:IDX_W+2] != '0);
    assign w_req_idx   = req_pc[IDX_W+1:2];
    assign w_ld_idx    = ld_addr[IDX_W+1:2];
    assign w_ld_unused = ^{ld_addr[31:IDX_W+2], ld_addr[1:0]};

    // Non-blocking ordering gives read-before-write when fetch and load hit the same word.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            r_mem[w_ld_idx] <= ld_data;
        end
        r_rd_data <= r_mem[w_req_idx];
    end

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic        r_v;
            logic        r_flt;
            logic [31:0] r_pc;
            if (gi == 0) begin : g_first
                // A request accepted in the flush cycle is not discarded.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_v   <= 1'b0;
                        r_flt <= 1'b0;
                        r_pc  <= '0;
                    end else begin
                        r_v <= w_accept;
                        if (w_accept) begin
                            r_flt <= w_fault;
                            r_pc  <= req_pc;
                        end
                    end
                end
                assign w_dat[gi] = r_rd_data;
            end else begin : g_next
                logic [31:0] r_dat;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_v   <= 1'b0;
                        r_flt <= 1'b0;
                        r_pc  <= '0;
                        r_dat <= '0;
                    end else begin
                        r_v   <= w_v[gi-1] & ~flush;
                        r_flt <= w_flt[gi-1];
                        r_pc  <= w_pc[gi-1];
                        r_dat <= w_dat[gi-1];
                    end
                end
                assign w_dat[gi] = r_dat;
            end
            assign w_v[gi]   = r_v;
            assign w_flt[gi] = r_flt;
            assign w_pc[gi]  = r_pc;
        end
    endgenerate

    assign w_push = w_v[LATENCY-1] & ~flush;
    assign w_pop  = resp_valid & resp_ready & ~flush;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_f_pc[r_wr]    <= w_pc[LATENCY-1];
            r_f_instr[r_wr] <= w_flt[LATENCY-1] ? 32'h0 : w_dat[LATENCY-1];
            r_f_fault[r_wr] <= w_flt[LATENCY-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= ptr_inc(r_wr);
            end
            if (w_pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Credits bound the in-flight plus buffered fetches, so the FIFO never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= CW'(OUT_DEPTH);
        end else if (flush) begin
            r_credits <= CW'(OUT_DEPTH) - CW'(w_accept);
        end else begin
            r_credits <= r_credits + CW'(w_pop) - CW'(w_accept);
        end
    end

    assign resp_valid = (r_count != '0);
    assign resp_pc    = resp_valid ? r_f_pc[r_rd]    : 32'h0;
    assign resp_instr = resp_valid ? r_f_instr[r_rd] : 32'h0;
    assign resp_fault = resp_valid ? r_f_fault[r_rd] : 1'b0;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: directed scenarios plus random traffic checked
// against a word-array/queue reference model.
`timescale 1ns/1ps
module tb_imem_fetch_unit;
    localparam int IDX_W     = 10;
    localparam int LATENCY   = 2;
    localparam int OUT_DEPTH = 3;
    localparam int DEPTH     = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready, resp_valid, resp_ready, resp_fault, flush, ld_we;
    logic [31:0] req_pc, resp_pc, resp_instr, ld_addr, ld_data;

    always #5 clk = ~clk;

    imem_fetch_unit #(.IDX_W(IDX_W), .LATENCY(LATENCY), .OUT_DEPTH(OUT_DEPTH), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pc(resp_pc),
        .resp_instr(resp_instr), .resp_fault(resp_fault), .flush(flush),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] mem_m [DEPTH];
    int          credits_m = OUT_DEPTH;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic resp_t expect_of(input logic [31:0] pc);
        resp_t r;
        r.pc    = pc;
        r.fault = ((pc % 4) != 0) || ((pc >> (IDX_W + 2)) != 0);
        r.instr = r.fault ? 32'h0 : mem_m[(pc >> 2) % DEPTH];
        return r;
    endfunction

    // Reference model: decides the upcoming edge from the stable inputs.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp_q.delete();
            credits_m = OUT_DEPTH;
        end else begin
            bit acc;
            bit pop;
            chk("req_ready", req_ready, credits_m != 0);
            acc = req_valid && (credits_m != 0);
            pop = resp_valid && resp_ready && !flush;
            if (flush) begin
                exp_q.delete();
                credits_m = OUT_DEPTH - int'(acc);
            end else begin
                credits_m = credits_m + int'(pop) - int'(acc);
            end
            if (acc) exp_q.push_back(expect_of(req_pc));
            if (ld_we) mem_m[(ld_addr >> 2) % DEPTH] = ld_data;
        end
    end

    // Monitor: compares each popped response and checks hold stability under backpressure.
    resp_t held;
    bit    hold_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", resp_valid, 1);
                chk("hold_pc", resp_pc, held.pc);
                chk("hold_instr", resp_instr, held.instr);
                chk("hold_fault", resp_fault, held.fault);
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_resp: got pc 0x%0h, required no response", resp_pc);
                end else if (resp_ready && !flush) begin
                    resp_t e;
                    e = exp_q.pop_front();
                    chk("resp_pc", resp_pc, e.pc);
                    chk("resp_instr", resp_instr, e.instr);
                    chk("resp_fault", resp_fault, e.fault);
                end
            end
            hold_prev  = resp_valid && !resp_ready && !flush;
            held.pc    = resp_pc;
            held.instr = resp_instr;
            held.fault = resp_fault;
        end
    end

    always @(negedge clk) begin
        if (rst_n && dut.w_push) chk("fifo_room", (dut.r_count < OUT_DEPTH) || dut.w_pop, 1);
    end

    task automatic issue(input logic [31:0] pc);
        int k;
        req_valid = 1'b1;
        req_pc    = pc;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        chk("issue_accepted", k < 200, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk); #3;
            if (exp_q.size() == 0 && !resp_valid) break;
        end
        chk("drain_done", k < 300, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst_n = 0; req_valid = 0; req_pc = 0; resp_ready = 0; flush = 0;
        ld_we = 0; ld_addr = 0; ld_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_pc", resp_pc, 0);
        chk("rst_resp_instr", resp_instr, 0);
        chk("rst_resp_fault", resp_fault, 0);
        chk("rst_req_ready", req_ready, 1);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) begin
            ld_we   = 1'b1;
            ld_addr = i * 4;
            ld_data = (i == 3) ? 32'h2002_0005 : $urandom;
            @(posedge clk); #1;
        end
        ld_we = 1'b0;

        // Single fetch latency and contents
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_pc     = 32'h0C;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int j = 0; j <= LATENCY; j++) begin
            @(negedge clk);
            chk("t1_latency", resp_valid, j == LATENCY);
        end
        chk("t1_pc", resp_pc, 32'h0C);
        chk("t1_instr", resp_instr, 32'h2002_0005);
        chk("t1_fault", resp_fault, 0);
        drain();

        // Back-to-back stream
        for (int k = 0; k < 4; k++) issue(k * 4);
        drain();

        // Backpressure: exactly OUT_DEPTH accepted
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        acc = 0;
        for (int k = 0; k < OUT_DEPTH + 4; k++) begin
            req_pc = $urandom_range(0, DEPTH - 1) << 2;
            @(negedge clk);
            if (req_ready) acc++;
            @(posedge clk); #1;
        end
        chk("t3_accepted", acc, OUT_DEPTH);
        @(negedge clk);
        chk("t3_ready_low", req_ready, 0);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        drain();

        // Faulting pcs
        issue(32'h6);
        issue(32'h1 << (IDX_W + 2));
        drain();

        // Flush with a surviving request
        resp_ready = 1'b0;
        issue(32'h0);
        issue(32'h4);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_pc    = 32'h40;
        @(negedge clk);
        chk("t5_ready", req_ready, 1);
        @(posedge clk); #1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("t5_credits", dut.r_credits, OUT_DEPTH);
        @(posedge clk); #1;

        // Load and fetch of the same word in one cycle
        req_valid = 1'b1;
        req_pc    = 32'h14;
        ld_we     = 1'b1;
        ld_addr   = 32'h14;
        ld_data   = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ld_we     = 1'b0;
        issue(32'h14);
        drain();

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 9))
                0:       req_pc = $urandom;
                1:       req_pc = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3);
                default: req_pc = $urandom_range(0, DEPTH - 1) << 2;
            endcase
            resp_ready = ($urandom_range(0, 9) < 7);
            ld_we      = ($urandom_range(0, 9) == 0);
            ld_addr    = $urandom;
            ld_data    = $urandom;
            flush      = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        req_valid = 0; ld_we = 0; flush = 0; resp_ready = 1;
        drain();

        // Reset with fetches in flight
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_pc = $urandom_range(0, DEPTH - 1) << 2;
            @(posedge clk); #1;
        end
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_pc", resp_pc, 0);
        chk("mid_rst_instr", resp_instr, 0);
        chk("mid_rst_ready", req_ready, 1);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", resp_valid, 0);
        end
        @(posedge clk); #1;
        issue(32'h20);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
